// File: rtl/opb_master_arbiter.sv
// ============================================================================
// Module   : opb_master_arbiter
// Brief    : Round-robin OPB arbiter with locked re-grant and optional
//            acknowledge watchdog (enabled by OPB_ARB_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   OPB_Clk,
  input  logic                   OPB_Rst,
  input  logic [NUM_MASTERS-1:0] M_request,
  input  logic [NUM_MASTERS-1:0] M_busLock,
  input  logic [NUM_MASTERS-1:0] M_select,
  input  logic                   OPB_xferAck,
  input  logic                   OPB_errAck,
  input  logic                   OPB_retry,
  output logic [NUM_MASTERS-1:0] OPB_MGrant,
  output logic                   OPB_timeout,
  output logic [1:0]             arb_owner,
  output logic                   arb_busy
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_GRANT     = 2'd1;
  localparam logic [1:0] c_ACQ       = 2'd2;
  localparam logic [1:0] c_BUSY      = 2'd3;
  localparam logic [1:0] c_RST_OWNER = 2'(NUM_MASTERS - 1);

  if ((NUM_MASTERS < 2) || (NUM_MASTERS > 4) ||
      (TIMEOUT_CYCLES < 4) || (TIMEOUT_CYCLES > 255)) begin : g_bad_params
    $error("opb_master_arbiter: parameter out of range");
  end

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [1:0]             r_owner;
  logic [1:0]             w_next_owner;
  logic [1:0]             w_winner;
  logic                   w_found;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_next_grant;
  logic [NUM_MASTERS-1:0] w_own_mask;
  logic                   w_own_sel;
  logic                   w_own_lock;
  logic                   w_own_req;

  assign w_own_mask = NUM_MASTERS'(1) << r_owner;
  assign w_own_sel  = |(M_select  & w_own_mask);
  assign w_own_lock = |(M_busLock & w_own_mask);
  assign w_own_req  = |(M_request & w_own_mask);

  // Rotating priority: search begins one past the last owner and wraps.
  always_comb begin
    w_winner = r_owner;
    w_found  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!w_found &&
          |(M_request & (NUM_MASTERS'(1) << ((int'(r_owner) + i) % NUM_MASTERS)))) begin
        w_found  = 1'b1;
        w_winner = 2'((int'(r_owner) + i) % NUM_MASTERS);
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state <= c_IDLE;
      r_owner <= c_RST_OWNER;
      r_grant <= '0;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_grant <= w_next_grant;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    case (r_state)
      c_IDLE: begin
        if (|M_request) begin
          w_next_state = c_GRANT;
          w_next_owner = w_winner;
        end
      end
      c_GRANT: w_next_state = c_ACQ;
      c_ACQ:   w_next_state = w_own_sel ? c_BUSY : c_IDLE;
      c_BUSY: begin
        // A locked owner still requesting keeps the bus without re-arbitration.
        if (!w_own_sel) begin
          w_next_state = (w_own_lock && w_own_req) ? c_GRANT : c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_next_grant = '0;
    if (w_next_state == c_GRANT) begin
      w_next_grant = NUM_MASTERS'(1) << w_next_owner;
    end
  end

  assign OPB_MGrant = r_grant;
  assign arb_owner  = r_owner;
  assign arb_busy   = (r_state != c_IDLE);

`ifdef OPB_ARB_TIMEOUT_EN
  localparam logic [7:0] c_WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wd_cnt;
  logic       r_timeout;
  logic       w_any_ack;

  assign w_any_ack = OPB_xferAck | OPB_errAck | OPB_retry;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == c_ACQ) begin
        r_wd_cnt <= '0;
      end else if (r_state == c_BUSY) begin
        if (w_any_ack) begin
          r_wd_cnt <= '0;
        end else if (r_wd_cnt == c_WD_LAST) begin
          r_timeout <= 1'b1;
          r_wd_cnt  <= '0;
        end else begin
          r_wd_cnt <= r_wd_cnt + 8'd1;
        end
      end
    end
  end

  assign OPB_timeout = r_timeout;
`else
  logic w_unused_ack;
  assign w_unused_ack = ^{OPB_xferAck, OPB_errAck, OPB_retry};
  assign OPB_timeout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_opb_master_arbiter.sv
// ============================================================================
// Module   : tb_opb_master_arbiter
// Brief    : Self-checking bench for opb_master_arbiter against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_opb_master_arbiter;

  localparam int N = 3;
  localparam int T = 16;
  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_ACQ   = 2;
  localparam int P_BUSY  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, lock, sel;
  logic         xack, eack, retry;
  logic [N-1:0] grant;
  logic         timeout;
  logic [1:0]   owner;
  logic         busy;

  always #5 clk = ~clk;

  opb_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) u_dut (
    .OPB_Clk    (clk),
    .OPB_Rst    (rst),
    .M_request  (req),
    .M_busLock  (lock),
    .M_select   (sel),
    .OPB_xferAck(xack),
    .OPB_errAck (eack),
    .OPB_retry  (retry),
    .OPB_MGrant (grant),
    .OPB_timeout(timeout),
    .arb_owner  (owner),
    .arb_busy   (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  // Reference model: bus phase, owner and watchdog count tracked abstractly.
  int m_phase = P_IDLE;
  int m_owner = N - 1;
  int m_cnt   = 0;
  int m_to    = 0;

  task automatic model_edge();
    int nph, nown;
    if (rst) begin
      m_phase = P_IDLE; m_owner = N - 1; m_cnt = 0; m_to = 0;
      return;
    end
    nph = m_phase; nown = m_owner; m_to = 0;
    if (m_phase == P_IDLE) begin
      if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (bit_of(req, (m_owner + k) % N)) begin
            nown = (m_owner + k) % N;
            break;
          end
        end
        nph = P_GRANT;
      end
    end else if (m_phase == P_GRANT) begin
      nph = P_ACQ;
    end else if (m_phase == P_ACQ) begin
      nph = bit_of(sel, m_owner) ? P_BUSY : P_IDLE;
      m_cnt = 0;
    end else begin
`ifdef OPB_ARB_TIMEOUT_EN
      if (xack || eack || retry) m_cnt = 0;
      else if (m_cnt == T - 1) begin m_to = 1; m_cnt = 0; end
      else m_cnt++;
`endif
      if (!bit_of(sel, m_owner))
        nph = (bit_of(lock, m_owner) && bit_of(req, m_owner)) ? P_GRANT : P_IDLE;
    end
    m_phase = nph; m_owner = nown;
  endtask

  // Simple master agents: after their grant, select for a_len cycles.
  bit agent_on = 1'b0;
  int a_len [N];
  bit a_nosel [N];
  int sel_left [N];
  int g1_count = 0;
  bit lock_mode = 1'b0;

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("grant", int'(grant), (m_phase == P_GRANT) ? int'(N'(1) << m_owner) : 0);
    check("owner", int'(owner), m_owner);
    check("busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
    check("timeout", int'(timeout), m_to);
    if (agent_on) begin
      for (int m = 0; m < N; m++) begin
        if (rst) sel_left[m] = 0;
        else if (m_phase == P_GRANT && m_owner == m && !a_nosel[m]) sel_left[m] = a_len[m];
        else if (sel_left[m] > 0) sel_left[m]--;
        sel[m] = (sel_left[m] > 0);
      end
      if (m_phase == P_GRANT && m_owner == 1) g1_count++;
      if (lock_mode) begin
        lock[1] = (g1_count < 3);
        if (g1_count >= 3) req[1] = 1'b0;
      end
    end
  endtask

  task automatic agents_reset(input int len);
    for (int m = 0; m < N; m++) begin
      a_len[m] = len; a_nosel[m] = 1'b0; sel_left[m] = 0;
    end
    sel = '0; lock = '0; agent_on = 1'b1; lock_mode = 1'b0;
  endtask

  task automatic drain(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  int seen, to_seen, busy_steps, entry, delay;

  initial begin
    rst = 1'b1; req = '0; lock = '0; sel = '0; xack = 0; eack = 0; retry = 0;
    agents_reset(3);
    step();
    step();
    rst = 1'b0;

    // Alternating grants between masters 0 and 1.
    req = 3'b011;
    for (int i = 0; i < 24; i++) step();
    drain(6);

    // Master 1 locked for three back-to-back transfers.
    agents_reset(2);
    lock_mode = 1'b1; g1_count = 0; lock[1] = 1'b1;
    req = 3'b011;
    for (int i = 0; i < 30; i++) step();
    lock_mode = 1'b0; lock = '0;
    check("lock_grants", g1_count, 3);
    drain(6);

    // Master 0 forfeits its grant; master 1 is served next.
    agents_reset(3);
    a_nosel[0] = 1'b1;
    req = 3'b011;
    for (int i = 0; i < 10; i++) step();
    drain(6);

    // Watchdog: no acknowledge during a long transfer.
    agents_reset(25);
    req = 3'b001; to_seen = 0; busy_steps = 0; entry = -1; delay = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_phase != P_IDLE) req = '0;
      if (m_phase == P_BUSY && entry < 0) entry = i;
      if (timeout) begin to_seen++; if (delay < 0) delay = i - entry; end
    end
`ifdef OPB_ARB_TIMEOUT_EN
    check("to_pulses", to_seen, 1);
    check("to_delay", delay, T);
`else
    check("to_pulses", to_seen, 0);
`endif
    drain(4);

    // Watchdog restarted by an acknowledge on the tenth BUSY cycle.
    agents_reset(35);
    req = 3'b001; to_seen = 0; busy_steps = 0; entry = -1; delay = -1;
    for (int i = 0; i < 45; i++) begin
      step();
      xack = 1'b0;
      if (m_phase != P_IDLE) req = '0;
      if (m_phase == P_BUSY) begin
        busy_steps++;
        if (busy_steps == 10) begin xack = 1'b1; entry = i + 1; end
      end
      if (timeout) begin to_seen++; if (delay < 0) delay = i - entry; end
    end
`ifdef OPB_ARB_TIMEOUT_EN
    check("ack_to_pulses", to_seen, 1);
    check("ack_to_delay", delay, T);
`else
    check("ack_to_pulses", to_seen, 0);
`endif
    drain(4);

    // Reset mid-transfer with master 1 owning the bus.
    agents_reset(10);
    req = 3'b010; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (m_phase == P_BUSY && m_owner == 1) seen = 1;
    end
    check("rst_setup", seen, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    agents_reset(3);
    req = 3'b011; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (grant != '0) begin seen = 1; check("first_after_rst", int'(owner), 0); end
    end
    check("grant_after_rst", seen, 1);
    drain(6);

    // Long held select.
    agents_reset(300);
    req = 3'b001;
    for (int i = 0; i < 310; i++) begin
      step();
      if (m_phase != P_IDLE) req = '0;
    end
    drain(4);

    // Randomized traffic including occasional resets and acknowledges.
    agent_on = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      req   = N'($urandom);
      lock  = N'($urandom);
      sel   = N'($urandom);
      xack  = ($urandom_range(7) == 0);
      eack  = ($urandom_range(15) == 0);
      retry = ($urandom_range(15) == 0);
      rst   = ($urandom_range(63) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
